// File: rtl/fpu_fma_sp_if.sv
// Serial operand/result bus of the single-precision FMA responder.
// master drives operands, slave returns the result.
interface fpu_fma_sp_if;
    logic        start;
    logic [31:0] float_in;
    logic [31:0] float_out;
    logic        ready;
    logic        error;

    modport master (
        output start, float_in,
        input  float_out, ready, error
    );

    modport slave (
        input  start, float_in,
        output float_out, ready, error
    );
endinterface

// File: rtl/fpu_fma_sp.sv
// Single-precision fused multiply-add y = a*b + c, one rounding (RNE, FTZ).
// Operands arrive serially after start; result pulses ready 7 cycles later.
module fpu_fma_sp #(
    parameter int          FLOAT_WIDTH = 32,
    parameter logic [31:0] CANON_NAN   = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    fpu_fma_sp_if.slave bus
);
    localparam int AW = 76;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_B = 3'd1;
    localparam logic [2:0] LOAD_C = 3'd2;
    localparam logic [2:0] MUL    = 3'd3;
    localparam logic [2:0] ALIGN  = 3'd4;
    localparam logic [2:0] ADD    = 3'd5;
    localparam logic [2:0] NORM   = 3'd6;
    localparam logic [2:0] ROUND  = 3'd7;

    logic [2:0]             state;
    logic [FLOAT_WIDTH-1:0] a_q, b_q, c_q;
    logic                   spec_q, spec_err_q;
    logic [31:0]            spec_val_q;
    logic                   sp_q, sc_q, czero_q;
    logic signed [10:0]     pe_q, e_q, ne_q;
    logic [47:0]            pm_q;
    logic [7:0]             ec_q;
    logic [23:0]            mc_q;
    logic [AW-1:0]          x_q, y_q, sum_q, nm_q;
    logic                   rs_q;
    logic [31:0]            out_q;
    logic                   rdy_q, err_q;

    assign bus.float_out = out_q;
    assign bus.ready     = rdy_q;
    assign bus.error     = err_q;

    function automatic logic [AW-1:0] rsj(input logic [AW-1:0] v, input logic [10:0] sh);
        logic [AW-1:0] m;
        if (sh >= 11'(AW)) return {{(AW-1){1'b0}}, |v};
        m = ~({AW{1'b1}} << sh);
        return (v >> sh) | {{(AW-1){1'b0}}, |(v & m)};
    endfunction

    function automatic logic [6:0] lzc(input logic [AW-1:0] v);
        logic [6:0] n;
        n = 7'(AW);
        for (int i = 0; i < AW; i++)
            if (v[i]) n = 7'(AW - 1 - i);
        return n;
    endfunction

    // MUL: classify operands, resolve special results, form the product
    logic [7:0]         ea, eb, ec;
    logic               a_zero, b_zero, c_zero, a_inf, b_inf, c_inf;
    logic               a_nan, b_nan, c_nan, p_sign, p_inf, p_zero;
    logic               spec_d, spec_err_d;
    logic [31:0]        spec_val_d;
    logic [47:0]        pm_d;
    logic signed [10:0] pe_d;

    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign ec     = c_q[30:23];
    assign a_zero = ea == 8'h00;
    assign b_zero = eb == 8'h00;
    assign c_zero = ec == 8'h00;
    assign a_inf  = ea == 8'hFF && a_q[22:0] == 23'h0;
    assign b_inf  = eb == 8'hFF && b_q[22:0] == 23'h0;
    assign c_inf  = ec == 8'hFF && c_q[22:0] == 23'h0;
    assign a_nan  = ea == 8'hFF && a_q[22:0] != 23'h0;
    assign b_nan  = eb == 8'hFF && b_q[22:0] != 23'h0;
    assign c_nan  = ec == 8'hFF && c_q[22:0] != 23'h0;
    assign p_sign = a_q[31] ^ b_q[31];
    assign p_inf  = a_inf | b_inf;
    assign p_zero = a_zero | b_zero;
    assign pm_d   = 48'({1'b1, a_q[22:0]}) * 48'({1'b1, b_q[22:0]});
    assign pe_d   = $signed({3'b0, ea}) + $signed({3'b0, eb}) - 11'sd127;

    always_comb begin
        spec_d     = 1'b1;
        spec_err_d = 1'b0;
        spec_val_d = CANON_NAN;
        if (a_nan | b_nan | c_nan) begin
            spec_err_d = 1'b0;
        end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
            spec_err_d = 1'b1;
        end else if (p_inf & c_inf & (p_sign != c_q[31])) begin
            spec_err_d = 1'b1;
        end else if (p_inf) begin
            spec_val_d = {p_sign, 8'hFF, 23'h0};
        end else if (c_inf) begin
            spec_val_d = {c_q[31], 8'hFF, 23'h0};
        end else if (p_zero & c_zero) begin
            spec_val_d = {p_sign & c_q[31], 31'h0};
        end else if (p_zero) begin
            spec_val_d = c_q;
        end else begin
            spec_d = 1'b0;
        end
    end

    // ALIGN: binary point of the accumulator sits at bit 72
    logic [AW-1:0]      px, cx, ax_d, ay_d;
    logic signed [10:0] d, ae_d;

    always_comb begin
        px   = {2'b0, pm_q, 26'b0};
        cx   = {3'b0, mc_q, 49'b0};
        d    = pe_q - $signed({3'b0, ec_q});
        ax_d = px;
        ay_d = cx;
        ae_d = pe_q;
        if (czero_q) begin
            ay_d = '0;
        end else if (d >= 0) begin
            ay_d = rsj(cx, d);
        end else begin
            ax_d = rsj(px, -d);
            ae_d = $signed({3'b0, ec_q});
        end
    end

    logic [AW-1:0] sum_d;
    logic          rs_d;

    always_comb begin
        sum_d = x_q + y_q;
        rs_d  = sp_q;
        if (sp_q ^ sc_q) begin
            if (x_q >= y_q) begin
                sum_d = x_q - y_q;
            end else begin
                sum_d = y_q - x_q;
                rs_d  = sc_q;
            end
        end
    end

    logic [6:0]         lz;
    logic [AW-1:0]      nm_d;
    logic signed [10:0] ne_d;

    assign lz   = lzc(sum_q);
    assign nm_d = sum_q << lz;
    assign ne_d = e_q + 11'sd3 - $signed({4'b0, lz});

    // ROUND: nm_q[75] is the hidden bit, clear only for an exact zero sum
    logic [22:0]        frac;
    logic               g, st;
    logic [23:0]        m24;
    logic signed [10:0] re;
    logic [31:0]        res_d;
    logic               err_d;

    assign frac = nm_q[74:52];
    assign g    = nm_q[51];
    assign st   = |nm_q[50:0];
    assign m24  = {1'b0, frac} + {23'b0, g & (st | frac[0])};
    assign re   = ne_q + $signed({10'b0, m24[23]});

    always_comb begin
        res_d = {rs_q, re[7:0], m24[22:0]};
        err_d = 1'b0;
        if (spec_q) begin
            res_d = spec_val_q;
            err_d = spec_err_q;
        end else if (!nm_q[75]) begin
            res_d = 32'h0;
        end else if (re >= 11'sd255) begin
            res_d = {rs_q, 8'hFF, 23'h0};
            err_d = 1'b1;
        end else if (re <= 11'sd0) begin
            res_d = {rs_q, 31'h0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            spec_q     <= 1'b0;
            spec_err_q <= 1'b0;
            spec_val_q <= '0;
            sp_q       <= 1'b0;
            sc_q       <= 1'b0;
            czero_q    <= 1'b0;
            pe_q       <= '0;
            e_q        <= '0;
            ne_q       <= '0;
            pm_q       <= '0;
            ec_q       <= '0;
            mc_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            sum_q      <= '0;
            nm_q       <= '0;
            rs_q       <= 1'b0;
            out_q      <= '0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.float_in;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    b_q   <= bus.float_in;
                    state <= LOAD_C;
                end
                LOAD_C: begin
                    c_q   <= bus.float_in;
                    state <= MUL;
                end
                MUL: begin
                    spec_q     <= spec_d;
                    spec_err_q <= spec_err_d;
                    spec_val_q <= spec_val_d;
                    sp_q       <= p_sign;
                    sc_q       <= c_q[31];
                    czero_q    <= c_zero;
                    pe_q       <= pe_d;
                    pm_q       <= pm_d;
                    ec_q       <= ec;
                    mc_q       <= {1'b1, c_q[22:0]};
                    state      <= ALIGN;
                end
                ALIGN: begin
                    x_q   <= ax_d;
                    y_q   <= ay_d;
                    e_q   <= ae_d;
                    state <= ADD;
                end
                ADD: begin
                    sum_q <= sum_d;
                    rs_q  <= rs_d;
                    state <= NORM;
                end
                NORM: begin
                    nm_q  <= nm_d;
                    ne_q  <= ne_d;
                    state <= ROUND;
                end
                ROUND: begin
                    out_q <= res_d;
                    err_q <= err_d;
                    rdy_q <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_fma_sp.sv
// Scenario bench for fpu_fma_sp: expected results queued at issue,
// popped and compared when ready pulses.
module tb_fpu_fma_sp;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [32:0] exp_q[$];
    logic [32:0] e;

    fpu_fma_sp_if bus();

    fpu_fma_sp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.float_in = a;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.float_in = b;
        @(negedge clk);
        bus.float_in = c;
    endtask

    task automatic wait_ready(input int from, output int cyc, output bit got);
        cyc = from;
        got = 1'b0;
        while (!got && cyc < from + 40) begin
            @(negedge clk);
            cyc++;
            if (bus.ready === 1'b1) got = 1'b1;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] eo, input logic ee,
                         output int cyc, output bit got);
        exp_q.push_back({ee, eo});
        send(a, b, c);
        wait_ready(2, cyc, got);
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.float_in = 32'h0;
        #12;
        total++;
        if (bus.float_out !== 32'h0 || bus.ready !== 1'b0 || bus.error !== 1'b0) begin
            bad++;
            $display("FAIL reset got=%h/%b/%b want=0/0/0", bus.float_out, bus.ready, bus.error);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int cyc;
        bit got;
        issue(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000, 1'b0, cyc, got);
        e = exp_q.pop_front();
        total++;
        if (!got || cyc != 8) begin
            bad++;
            $display("FAIL basic_latency got=%0d want=8 seen=%0b", cyc, got);
        end
        total++;
        if (bus.float_out !== e[31:0] || bus.error !== e[32]) begin
            bad++;
            $display("FAIL basic_out got=%h/%b want=%h/%b", bus.float_out, bus.error, e[31:0], e[32]);
        end
        @(negedge clk);
        total++;
        if (bus.ready !== 1'b0 || bus.float_out !== 32'h40A0_0000) begin
            bad++;
            $display("FAIL basic_pulse ready=%b out=%h want 0/40a00000", bus.ready, bus.float_out);
        end
    endtask

    task automatic test_arith;
        logic [31:0] va[7];
        logic [31:0] vb[7];
        logic [31:0] vc[7];
        logic [31:0] vo[7];
        int cyc;
        bit got;
        va = '{32'h3FC0_0000, 32'h3F80_0001, 32'h3F80_0000, 32'h3F80_0000,
               32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000};
        vb = '{32'hC000_0000, 32'h3F80_0001, 32'h3F80_0000, 32'h3F80_0000,
               32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        vc = '{32'h4040_0000, 32'h0000_0000, 32'hC080_0000, 32'h3080_0000,
               32'h33C0_0000, 32'h3380_0000, 32'h3F80_0000};
        vo = '{32'h0000_0000, 32'h3F80_0002, 32'hC040_0000, 32'h3F80_0000,
               32'h3F80_0001, 32'h3F80_0000, 32'h0000_0000};
        for (int i = 0; i < 7; i++) begin
            issue(va[i], vb[i], vc[i], vo[i], 1'b0, cyc, got);
            e = exp_q.pop_front();
            total++;
            if (!got || bus.float_out !== e[31:0] || bus.error !== e[32]) begin
                bad++;
                $display("FAIL arith_%0d got=%h/%b want=%h/%b seen=%0b",
                         i, bus.float_out, bus.error, e[31:0], e[32], got);
            end
        end
    endtask

    task automatic test_special;
        logic [31:0] va[6];
        logic [31:0] vb[6];
        logic [31:0] vc[6];
        logic [31:0] vo[6];
        logic        ve[6];
        int cyc;
        bit got;
        va = '{32'h0000_0001, 32'h7F80_0000, 32'h7F80_0001, 32'h7F80_0000,
               32'h7F80_0000, 32'h7F7F_FFFF};
        vb = '{32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000,
               32'h4000_0000, 32'h4000_0000};
        vc = '{32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'hFF80_0000,
               32'h40A0_0000, 32'h0000_0000};
        vo = '{32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000,
               32'h7F80_0000, 32'h7F80_0000};
        ve = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], vc[i], vo[i], ve[i], cyc, got);
            e = exp_q.pop_front();
            total++;
            if (!got || bus.float_out !== e[31:0] || bus.error !== e[32]) begin
                bad++;
                $display("FAIL special_%0d got=%h/%b want=%h/%b seen=%0b",
                         i, bus.float_out, bus.error, e[31:0], e[32], got);
            end
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit got;
        int pulses;
        send(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (bus.float_out !== 32'h0 || bus.ready !== 1'b0 || bus.error !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got=%h/%b/%b want=0/0/0", bus.float_out, bus.ready, bus.error);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL reset_abort ready_pulses=%0d want=0", pulses);
        end
        issue(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000, 1'b0, cyc, got);
        e = exp_q.pop_front();
        total++;
        if (!got || cyc != 8 || bus.float_out !== e[31:0] || bus.error !== e[32]) begin
            bad++;
            $display("FAIL reset_recover got=%h/%b cyc=%0d want=%h/%b cyc=8",
                     bus.float_out, bus.error, cyc, e[31:0], e[32]);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit got;
        exp_q.push_back({1'b0, 32'h40A0_0000});
        exp_q.push_back({1'b0, 32'hC040_0000});
        send(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.float_in = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.float_in = 32'h0;
        wait_ready(4, cyc, got);
        e = exp_q.pop_front();
        total++;
        if (!got || cyc != 8 || bus.float_out !== e[31:0] || bus.error !== e[32]) begin
            bad++;
            $display("FAIL b2b_first got=%h/%b cyc=%0d want=%h/%b cyc=8",
                     bus.float_out, bus.error, cyc, e[31:0], e[32]);
        end
        bus.start    = 1'b1;
        bus.float_in = 32'h3F80_0000;
        @(negedge clk);
        total++;
        if (bus.ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_pulse ready=%b want=0", bus.ready);
        end
        bus.start    = 1'b0;
        bus.float_in = 32'h3F80_0000;
        @(negedge clk);
        bus.float_in = 32'hC080_0000;
        wait_ready(10, cyc, got);
        e = exp_q.pop_front();
        total++;
        if (!got || cyc != 16 || bus.float_out !== e[31:0] || bus.error !== e[32]) begin
            bad++;
            $display("FAIL b2b_second got=%h/%b cyc=%0d want=%h/%b cyc=16",
                     bus.float_out, bus.error, cyc, e[31:0], e[32]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_special();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
